// File: rtl/wb_pkg.sv
// Shared types, default widths and helpers for the Wishbone register-file slave.
// Default bus widths come from the ADDR_WIDTH / DATA_WIDTH macros when the build provides them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package wb_pkg;

   localparam int WB_ADDR_WIDTH_DEF = `ADDR_WIDTH;
   localparam int WB_DATA_WIDTH_DEF = `DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } wb_state_t;

   function automatic int SEL_WIDTH(input int dw);
      return dw / 8;
   endfunction

   // One byte lane of a masked merge: take the new byte where the lane is enabled.
   function automatic logic [7:0] lane_merge(input logic [7:0] old_b,
                                             input logic [7:0] new_b,
                                             input logic       en);
      return en ? new_b : old_b;
   endfunction

endpackage

// File: rtl/wb_slave_fsm.sv
// IDLE/WAIT/RESP sequencer with wait-state counter for the Wishbone register-file slave.
// The current state is exported on o_state for observation.
module wb_slave_fsm
   import wb_pkg::*;
#(
   parameter int WAIT_STATES = 0
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      cyc_i,
   input  logic      stb_i,
   output logic      o_capture,
   output logic      o_commit,
   output wb_state_t o_state
);

   localparam logic [3:0] WS_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   wb_state_t  r_state;
   wb_state_t  w_next;
   logic [3:0] r_cnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_next == WAIT)
            r_cnt <= WS_LAST;
         else if (r_state == WAIT && w_next == WAIT)
            r_cnt <= r_cnt - 4'd1;
         else
            r_cnt <= '0;
      end
   end

   // A request is cyc_i&stb_i seen in IDLE; the master holds it until ack/err.
   // Dropping cyc_i before RESP is entered abandons the transfer.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (cyc_i && stb_i) w_next = (WAIT_STATES > 0) ? WAIT : RESP;
         WAIT: begin
            if (!cyc_i)
               w_next = IDLE;
            else if (r_cnt == 4'd0)
               w_next = RESP;
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      o_capture = (r_state == IDLE) && cyc_i && stb_i;
      o_commit  = (w_next == RESP) && (r_state != RESP);
      o_state   = r_state;
   end

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone B4 classic slave: NUM_REGS registers, byte-lane writes, wait states, ID at index 0.
// Define WB_REGFILE_ERR_EN to terminate out-of-range accesses with err_o instead of ack_o.
module wb_slave_regfile
   import wb_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = WB_ADDR_WIDTH_DEF,
   parameter int                    DATA_WIDTH  = WB_DATA_WIDTH_DEF,
   parameter int                    NUM_REGS    = 8,
   parameter int                    WAIT_STATES = 0,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'h5742_0001),
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [ADDR_WIDTH-1:0]   adr_i,
   input  logic [DATA_WIDTH-1:0]   dat_i,
   output logic [DATA_WIDTH-1:0]   dat_o,
   input  logic [DATA_WIDTH/8-1:0] sel_i,
   input  logic                    we_i,
   input  logic                    cyc_i,
   input  logic                    stb_i,
   output logic                    ack_o,
   output logic                    err_o
);

   localparam int SW    = SEL_WIDTH(DATA_WIDTH);
   localparam int OFS_W = $clog2(SW);
   localparam int IDX_W = $clog2(NUM_REGS);

   logic                  w_capture;
   logic                  w_commit;
   wb_state_t             w_state;

   logic [ADDR_WIDTH-1:0] r_adr;
   logic [DATA_WIDTH-1:0] r_dat;
   logic [SW-1:0]         r_sel;
   logic                  r_we;
   logic [DATA_WIDTH-1:0] r_regs [1:NUM_REGS-1];
   logic [DATA_WIDTH-1:0] r_dat_o;

   logic [ADDR_WIDTH-1:0] w_adr;
   logic [DATA_WIDTH-1:0] w_dat;
   logic [SW-1:0]         w_sel;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_idx_full;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_in_range;
   logic [DATA_WIDTH-1:0] w_rd_arr [NUM_REGS];
   logic [DATA_WIDTH-1:0] w_cur;
   logic [DATA_WIDTH-1:0] w_merged;
   logic [DATA_WIDTH-1:0] w_rd_masked;

   wb_slave_fsm #(
      .WAIT_STATES (WAIT_STATES)
   ) u_fsm (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .cyc_i     (cyc_i),
      .stb_i     (stb_i),
      .o_capture (w_capture),
      .o_commit  (w_commit),
      .o_state   (w_state)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_adr <= '0;
         r_dat <= '0;
         r_sel <= '0;
         r_we  <= 1'b0;
      end else if (w_capture) begin
         r_adr <= adr_i;
         r_dat <= dat_i;
         r_sel <= sel_i;
         r_we  <= we_i;
      end
   end

   // With no wait states capture and commit share an edge, so use the live bus then.
   always_comb begin
      w_adr      = w_capture ? adr_i : r_adr;
      w_dat      = w_capture ? dat_i : r_dat;
      w_sel      = w_capture ? sel_i : r_sel;
      w_we       = w_capture ? we_i  : r_we;
      w_idx_full = w_adr >> OFS_W;
      w_idx      = w_idx_full[IDX_W-1:0];
      w_in_range = w_idx_full < ADDR_WIDTH'(NUM_REGS);
   end

   always_comb begin
      w_rd_arr[0] = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++)
         w_rd_arr[i] = r_regs[i];
      w_cur       = w_rd_arr[w_idx];
      w_merged    = '0;
      w_rd_masked = '0;
      for (int b = 0; b < SW; b++) begin
         w_merged[8*b +: 8]    = lane_merge(w_cur[8*b +: 8], w_dat[8*b +: 8], w_sel[b]);
         w_rd_masked[8*b +: 8] = lane_merge(8'h00, w_cur[8*b +: 8], w_sel[b]);
      end
   end

   // Index 0 has no storage, so writes to the ID register fall through harmlessly.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 1; i < NUM_REGS; i++)
            r_regs[i] <= RESET_VALUE;
      end else if (w_commit && w_we && w_in_range) begin
         for (int i = 1; i < NUM_REGS; i++)
            if (w_idx == IDX_W'(i))
               r_regs[i] <= w_merged;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_dat_o <= '0;
      end else if (w_commit) begin
         if (!w_we)
            r_dat_o <= w_in_range ? w_rd_masked : '0;
`ifdef WB_REGFILE_ERR_EN
         else if (!w_in_range)
            r_dat_o <= '0;
`endif
      end
   end

   assign dat_o = r_dat_o;

`ifdef WB_REGFILE_ERR_EN
   logic r_oor;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         r_oor <= 1'b0;
      else if (w_commit)
         r_oor <= !w_in_range;
   end

   always_comb begin
      ack_o = (w_state == RESP) && !r_oor;
      err_o = (w_state == RESP) && r_oor;
   end
`else
   always_comb begin
      ack_o = (w_state == RESP);
      err_o = 1'b0;
   end
`endif

endmodule
